// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     frame_err,
  output logic                     overflow,
  output logic                     parity_err
);
  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
  localparam int FL      = FIFO_DEPTH_LOG2;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, nxt;
  logic rx_m, rxs, armed, tick, bit_ctr, start_det, push_ok, fe, pe, par_bad;
  logic [1:0] vld;
  logic [DW-1:0] div_cnt;
  logic [3:0] tc;
  logic [2:0] idx;
  logic [7:0] sh;
  logic [7:0] mem [1<<FL];
  logic [FL-1:0] wp, rp;
  logic do_push, do_pop;
  assign tick      = div_cnt == DW'(DIV - 1);
  assign bit_ctr   = tick && tc == 4'd15;
  assign start_det = state == IDLE && armed && !rxs;
  always_comb begin
    nxt = state;
    push_ok = 1'b0;
    fe = 1'b0;
    pe = 1'b0;
    case (state)
      IDLE:   nxt = start_det ? START : IDLE;
      START:  nxt = (tick && tc == 4'd7) ? (rxs ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   nxt = (bit_ctr && idx == 3'd7) ? PARITY : DATA;
      PARITY: nxt = bit_ctr ? STOP : PARITY;
`else
      DATA:   nxt = (bit_ctr && idx == 3'd7) ? STOP : DATA;
`endif
      STOP: begin
        nxt = bit_ctr ? IDLE : STOP;
        push_ok = bit_ctr && rxs && !par_bad;
        fe = bit_ctr && !rxs;
        pe = bit_ctr && par_bad;
      end
      default: nxt = IDLE;
    endcase
  end
  // vld keeps the reset value of the synchroniser from arming the receiver
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_m <= 1'b1;
      rxs <= 1'b1;
      vld <= 2'b00;
      armed <= 1'b0;
      state <= IDLE;
      div_cnt <= '0;
      tc <= 4'd0;
      idx <= 3'd0;
      sh <= 8'h00;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rxs <= rx_m;
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & rxs);
      state <= nxt;
      div_cnt <= (start_det || tick) ? '0 : div_cnt + 1'b1;
      tc <= start_det ? 4'd0 : tick ? ((state == START && tc == 4'd7) ? 4'd0 : tc + 4'd1) : tc;
      idx <= start_det ? 3'd0 : (state == DATA && bit_ctr) ? idx + 3'd1 : idx;
      sh <= (state == DATA && bit_ctr) ? {rxs, sh[7:1]} : sh;
      frame_err <= fe;
      parity_err <= pe;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) par_bad <= 1'b0;
    else par_bad <= start_det ? 1'b0 : (state == PARITY && bit_ctr) ? ^{sh, rxs} : par_bad;
  end
`else
  assign par_bad = 1'b0;
`endif
  assign empty   = count == '0;
  assign full    = count[FL];
  assign dout    = empty ? 8'h00 : mem[rp];
  assign do_pop  = rd_en && !empty;
  assign do_push = push_ok && (!full || do_pop);
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wp] <= sh;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (FL+1)'(do_push) - (FL+1)'(do_pop);
      overflow <= (push_ok && full && !do_pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;
  logic clk_in = 1'b0, rst_in = 1'b1, rx = 1'b1, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] dout;
  logic empty, full, frame_err, overflow, parity_err;
  logic [3:0] count;
  int checks = 0, errors = 0, fe_cnt = 0, pe_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b, d_at_push;
  logic e_pre, e_post, pop_at_push = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PUSH = 10 + 16 * (NB - 1);

  uart_rx_fifo #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH_LOG2(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx(rx), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overflow(overflow), .parity_err(parity_err));

  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) begin
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    logic b [NB];
    int n;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9] = par;
    b[NB-1] = stop;
    n = 0;
    for (int k = 0; k < NB; k++) begin
      rx = b[k];
      repeat (16) begin
        @(negedge clk_in);
        n++;
        if (n == PUSH) begin
          e_pre = empty;
          if (pop_at_push) begin
            d_at_push = dout;
            rd_en = 1'b1;
          end
        end
        if (n == PUSH + 1) begin
          e_post = empty;
          rd_en = 1'b0;
        end
      end
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if ({dout, empty, full, count, frame_err, overflow, parity_err} !== {8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", {dout, empty, full, count, frame_err, overflow, parity_err}, {8'h00, 1'b1, 1'b0, 4'd0, 3'b000});
    end
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic test_single();
    q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    checks++;
    if (e_pre !== 1'b1 || e_post !== 1'b0) begin
      errors++;
      $display("FAIL single_latency got empty %b->%b expected 1->0", e_pre, e_post);
    end
    exp_b = q.pop_front();
    checks++;
    if (dout !== exp_b || count !== 4'd1) begin
      errors++;
      $display("FAIL single_data got %h/%0d expected %h/1", dout, count, exp_b);
    end
    pop();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL single_pop got empty %b count %0d expected 1/0", empty, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [3] = '{8'h00, 8'hFF, 8'h3C};
    int fe0 = fe_cnt;
    foreach (v[i]) begin
      q.push_back(v[i]);
      send_frame(v[i], 1'b1, ^v[i]);
    end
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      exp_b = q.pop_front();
      checks++;
      if (empty !== 1'b0 || dout !== exp_b) begin
        errors++;
        $display("FAIL b2b_data got %h empty %b expected %h", dout, empty, exp_b);
      end
      pop();
    end
    checks++;
    if (fe_cnt !== fe0) begin
      errors++;
      $display("FAIL b2b_frame_err got %0d pulses expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b1;
    repeat (40) @(negedge clk_in);
    checks++;
    if (fe_cnt - fe0 !== 1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_err got %0d cycles empty %b expected 1 cycle empty 1", fe_cnt - fe0, empty);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk_in);
    rx = 1'b1;
    repeat (30) @(negedge clk_in);
    checks++;
    if (empty !== 1'b1 || fe_cnt !== fe0) begin
      errors++;
      $display("FAIL glitch got empty %b errs %0d expected 1/0", empty, fe_cnt - fe0);
    end
    q.push_back(8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    exp_b = q.pop_front();
    checks++;
    if (empty !== 1'b0 || dout !== exp_b) begin
      errors++;
      $display("FAIL glitch_next got %h expected %h", dout, exp_b);
    end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      if (q.size() < 8) q.push_back(8'(i));
      send_frame(8'(i), 1'b1, ^8'(i));
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_flags got full %b ovf %b count %0d expected 1/1/8", full, overflow, count);
    end
    ovf_clr = 1'b1;
    @(negedge clk_in);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b expected 0", overflow);
    end
    pop_at_push = 1'b1;
    send_frame(8'h0A, 1'b1, ^8'h0A);
    pop_at_push = 1'b0;
    exp_b = q.pop_front();
    q.push_back(8'h0A);
    checks++;
    if (d_at_push !== exp_b || count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full got %h count %0d ovf %b expected %h/8/0", d_at_push, count, overflow, exp_b);
    end
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      checks++;
      if (empty !== 1'b0 || dout !== exp_b) begin
        errors++;
        $display("FAIL ovf_data got %h empty %b expected %h", dout, empty, exp_b);
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got empty %b full %b expected 1/0", empty, full);
    end
  endtask

  task automatic test_reset_mid();
    int fe0;
    for (int i = 0; i < 3; i++) send_frame(8'(8'h40 + i), 1'b1, ^8'(8'h40 + i));
    rx = 1'b0;
    repeat (40) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    q.delete();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid got empty %b count %0d expected 1/0", empty, count);
    end
    fe0 = fe_cnt;
    repeat (250) @(negedge clk_in);
    checks++;
    if (empty !== 1'b1 || fe_cnt !== fe0) begin
      errors++;
      $display("FAIL reset_low_line got empty %b errs %0d expected 1/0", empty, fe_cnt - fe0);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk_in);
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    exp_b = q.pop_front();
    checks++;
    if (empty !== 1'b0 || dout !== exp_b) begin
      errors++;
      $display("FAIL reset_recover got %h expected %h", dout, exp_b);
    end
    pop();
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int pe0 = pe_cnt, fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk_in);
    checks++;
    if (pe_cnt - pe0 !== 1 || fe_cnt !== fe0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL parity got pe %0d fe %0d empty %b expected 1/0/1", pe_cnt - pe0, fe_cnt - fe0, empty);
    end
`else
    checks++;
    if (pe_cnt !== 0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_tied got %0d pulses expected 0", pe_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overflow();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
